// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch
//  Description : Instruction-fetch unit. Drives the PC onto the instruction
//                bus under a credit limit, buffers returned words with their
//                addresses and presents them to the IF/ID register. Handles
//                jump redirects (flush + stale-response dropping) and hold.
//  Revision    : 1.0  initial release
// ============================================================================
module ifu_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int unsigned        c_ptr_w   = $clog2(BUF_DEPTH);
    localparam int unsigned        c_cnt_w   = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w:0]   c_depth   = (c_cnt_w + 1)'(BUF_DEPTH);

    // Note: rst_n is active-HIGH despite its name (1 = reset).
    logic [31:0]        r_pc_q,      w_pc_d;
    logic [c_cnt_w-1:0] r_outst_q,   w_outst_d;
    logic [c_cnt_w-1:0] r_drop_q,    w_drop_d;
    logic [c_ptr_w-1:0] r_af_wptr_q, w_af_wptr_d;
    logic [c_ptr_w-1:0] r_af_rptr_q, w_af_rptr_d;
    logic [c_ptr_w-1:0] r_rb_wptr_q, w_rb_wptr_d;
    logic [c_ptr_w-1:0] r_rb_rptr_q, w_rb_rptr_d;
    logic [c_cnt_w-1:0] r_rb_cnt_q,  w_rb_cnt_d;

    logic [31:0] r_af_addr_q [BUF_DEPTH];
    logic [31:0] r_rb_addr_q [BUF_DEPTH];
    logic [31:0] r_rb_data_q [BUF_DEPTH];

    logic [c_cnt_w:0] w_credit_used;
    logic             w_hs;
    logic             w_dropping;
    logic             w_keep;
    logic             w_af_pop;
    logic             w_pop;

    // Handshake, credit and buffer-control decode
    always_comb begin
        w_credit_used = {1'b0, r_outst_q} + {1'b0, r_rb_cnt_q};
        ibus_req_o    = !rst_n && (w_credit_used < c_depth) && !jump_en_i;
        ibus_addr_o   = r_pc_q;
        w_hs          = ibus_req_o && ibus_gnt_i;
        w_dropping    = (r_drop_q != '0);
        // A response consumes an address-FIFO entry only if it is not stale;
        // stale responses belong to addresses already flushed by a redirect.
        w_af_pop      = ibus_rvalid_i && !w_dropping;
        w_keep        = w_af_pop && !jump_en_i;
        inst_valid_o  = (r_rb_cnt_q != '0);
        w_pop         = inst_valid_o && !hold_i;
        inst_o        = inst_valid_o ? r_rb_data_q[r_rb_rptr_q] : NOP_INST;
        inst_addr_o   = inst_valid_o ? r_rb_addr_q[r_rb_rptr_q] : 32'h0;
    end

    // Next-state computation for PC, counters and pointers
    always_comb begin
        w_pc_d      = r_pc_q;
        w_outst_d   = r_outst_q + (w_hs ? c_cnt_one : '0) - (ibus_rvalid_i ? c_cnt_one : '0);
        w_drop_d    = r_drop_q;
        w_af_wptr_d = r_af_wptr_q;
        w_af_rptr_d = r_af_rptr_q;
        w_rb_wptr_d = r_rb_wptr_q;
        w_rb_rptr_d = r_rb_rptr_q;
        w_rb_cnt_d  = r_rb_cnt_q + (w_keep ? c_cnt_one : '0) - (w_pop ? c_cnt_one : '0);
        if (jump_en_i) begin
            // Everything still in flight after this edge becomes stale.
            w_pc_d      = jump_addr_i;
            w_drop_d    = r_outst_q - (ibus_rvalid_i ? c_cnt_one : '0);
            w_af_wptr_d = '0;
            w_af_rptr_d = '0;
            w_rb_wptr_d = '0;
            w_rb_rptr_d = '0;
            w_rb_cnt_d  = '0;
        end else begin
            if (w_hs) begin
                w_pc_d      = r_pc_q + 32'd4;
                w_af_wptr_d = r_af_wptr_q + c_ptr_one;
            end
            if (ibus_rvalid_i && w_dropping) begin
                w_drop_d = r_drop_q - c_cnt_one;
            end
            if (w_af_pop) begin
                w_af_rptr_d = r_af_rptr_q + c_ptr_one;
            end
            if (w_keep) begin
                w_rb_wptr_d = r_rb_wptr_q + c_ptr_one;
            end
            if (w_pop) begin
                w_rb_rptr_d = r_rb_rptr_q + c_ptr_one;
            end
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_pc_q      <= RESET_PC;
            r_outst_q   <= '0;
            r_drop_q    <= '0;
            r_af_wptr_q <= '0;
            r_af_rptr_q <= '0;
            r_rb_wptr_q <= '0;
            r_rb_rptr_q <= '0;
            r_rb_cnt_q  <= '0;
        end else begin
            r_pc_q      <= w_pc_d;
            r_outst_q   <= w_outst_d;
            r_drop_q    <= w_drop_d;
            r_af_wptr_q <= w_af_wptr_d;
            r_af_rptr_q <= w_af_rptr_d;
            r_rb_wptr_q <= w_rb_wptr_d;
            r_rb_rptr_q <= w_rb_rptr_d;
            r_rb_cnt_q  <= w_rb_cnt_d;
        end
    end

    // Storage arrays; validity is tracked by the pointers/count above
    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_af_addr_q[r_af_wptr_q] <= r_pc_q;
        end
        if (w_keep) begin
            r_rb_addr_q[r_rb_wptr_q] <= r_af_addr_q[r_af_rptr_q];
            r_rb_data_q[r_rb_wptr_q] <= ibus_rdata_i;
        end
    end

    // A response with nothing in flight is a bus protocol violation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            assert (!(ibus_rvalid_i && (r_outst_q == '0)));
        end
    end

endmodule
`default_nettype wire
